// File: rtl/sipo_deser.sv
// MSB-first serial-to-parallel deserializer with a single-word output slot
// under a valid/ready handshake; completed words that find the slot full are dropped.
module sipo_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] pout_next;
  logic             ovalid_next;
  logic             over_next;
  logic             word_done;
  logic             slot_open;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    shift_next  = shift_reg;
    pout_next   = parallel_out;
    ovalid_next = out_valid;
    over_next   = 1'b0;
    word_done   = 1'b0;
    slot_open   = !out_valid || out_ready;

    // A realign that carries a bit starts a fresh word at count 1.
    if (bit_valid && frame_start) begin
      shift_next = {{(WIDTH-1){1'b0}}, serial_in};
      cnt_next   = CNT_W'(1);
      state_next = COLLECT;
    end else if (bit_valid) begin
      shift_next = {shift_reg[WIDTH-2:0], serial_in};
      if (cnt == LAST) begin
        word_done  = 1'b1;
        cnt_next   = '0;
        state_next = IDLE;
      end else begin
        cnt_next   = cnt + 1'b1;
        state_next = COLLECT;
      end
    end else if (frame_start) begin
      shift_next = '0;
      cnt_next   = '0;
      state_next = IDLE;
    end

    // A completing word may replace a word that is draining this same edge.
    if (word_done) begin
      if (slot_open) begin
        pout_next   = shift_next;
        ovalid_next = 1'b1;
      end else begin
        over_next = 1'b1;
      end
    end else if (out_valid && out_ready) begin
      ovalid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg    <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      shift_reg    <= shift_next;
      parallel_out <= pout_next;
      out_valid    <= ovalid_next;
      overrun      <= over_next;
      busy         <= (state_next == COLLECT);
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser (WIDTH=8): directed scenarios plus random traffic,
// checked every cycle against a word-level model and against hand-computed literals.
module tb_sipo_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         serial_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] parallel_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;

  sipo_deser #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .frame_start  (frame_start),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Word-level model: bits gathered as an integer, slot as value + flag.
  int           m_n = 0;
  logic [31:0]  m_acc = '0;
  logic [W-1:0] m_pout = '0;
  logic         m_valid = 1'b0;
  logic         m_over = 1'b0;
  logic         m_busy = 1'b0;

  int n_checks = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  // Literal expectations handed to the compare process.
  int           dir_seq = 0;
  int           dir_seen = 0;
  string        dir_name = "";
  logic [W-1:0] dir_pout = '0;
  logic         dir_valid = 1'b0;
  logic         dir_busy = 1'b0;
  logic         dir_over = 1'b0;

  task automatic model_step();
    logic         done;
    logic [W-1:0] word;
    done = 1'b0;
    word = '0;
    if (rst) begin
      m_n = 0; m_acc = '0; m_pout = '0; m_valid = 1'b0; m_over = 1'b0; m_busy = 1'b0;
    end else begin
      m_over = 1'b0;
      if (bit_valid && frame_start) begin
        m_acc = {31'd0, serial_in};
        m_n = 1;
      end else if (bit_valid) begin
        m_acc = (m_acc << 1) | {31'd0, serial_in};
        m_n = m_n + 1;
        if (m_n == W) begin
          done = 1'b1;
          word = m_acc[W-1:0];
          m_n = 0;
          m_acc = '0;
        end
      end else if (frame_start) begin
        m_n = 0;
        m_acc = '0;
      end
      if (done) begin
        if (!m_valid || out_ready) begin
          m_pout = word;
          m_valid = 1'b1;
        end else begin
          m_over = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      m_busy = (m_n != 0);
    end
  endtask

  task automatic cycle(input logic bv, input logic sb, input logic fs,
                       input logic rdy, input logic rs);
    bit_valid = bv;
    serial_in = sb;
    frame_start = fs;
    out_ready = rdy;
    rst = rs;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy);
    for (int i = W - 1; i >= 0; i--) cycle(1'b1, w[i], 1'b0, rdy, 1'b0);
  endtask

  task automatic expect_lit(input string nm, input logic [W-1:0] p, input logic v,
                            input logic b, input logic o);
    dir_name = nm;
    dir_pout = p;
    dir_valid = v;
    dir_busy = b;
    dir_over = o;
    dir_seq = dir_seq + 1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_pout", 32'(parallel_out), 32'(m_pout));
      check("model_valid", 32'(out_valid), 32'(m_valid));
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_overrun", 32'(overrun), 32'(m_over));
    end
    if (dir_seq != dir_seen) begin
      dir_seen = dir_seq;
      check({dir_name, "_pout"}, 32'(parallel_out), 32'(dir_pout));
      check({dir_name, "_valid"}, 32'(out_valid), 32'(dir_valid));
      check({dir_name, "_busy"}, 32'(busy), 32'(dir_busy));
      check({dir_name, "_overrun"}, 32'(overrun), 32'(dir_over));
    end
  end

  initial begin
    logic [W-1:0] a5;
    logic [W-1:0] c3;
    a5 = 8'hA5;
    c3 = 8'hC3;

    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_on = 1'b1;
    expect_lit("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Basic word with the sink always ready.
    cycle(1'b1, a5[7], 1'b0, 1'b1, 1'b0);
    expect_lit("first_bit", 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) cycle(1'b1, a5[i], 1'b0, 1'b1, 1'b0);
    expect_lit("basic_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_lit("basic_drain", 8'hA5, 1'b0, 1'b0, 1'b0);

    // Backpressure: second word is dropped with an overrun pulse.
    send_word(8'h3C, 1'b0);
    expect_lit("bp_first", 8'h3C, 1'b1, 1'b0, 1'b0);
    send_word(8'hF0, 1'b0);
    expect_lit("bp_overrun", 8'h3C, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_lit("bp_pulse_end", 8'h3C, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_lit("bp_drain", 8'h3C, 1'b0, 1'b0, 1'b0);

    // Drain and completion on the same edge.
    send_word(8'h11, 1'b0);
    for (int i = 7; i >= 1; i--) cycle(1'b1, 1'(8'h22 >> i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_lit("drain_complete", 8'h22, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Gapped bits of 0x81.
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b1, 1'(8'h81 >> i), 1'b0, 1'b1, 1'b0);
      if (i != 0) repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    expect_lit("gapped", 8'h81, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Realign after a 5-bit partial word.
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, c3[7], 1'b1, 1'b1, 1'b0);
    expect_lit("realign_start", 8'h81, 1'b0, 1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) cycle(1'b1, c3[i], 1'b0, 1'b1, 1'b0);
    expect_lit("realign", 8'hC3, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // frame_start without a bit clears a partial word only.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_lit("fs_clear", 8'hC3, 1'b0, 1'b0, 1'b0);

    // Reset mid-word with a pending output word.
    send_word(8'h99, 1'b0);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_lit("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
    send_word(8'h5A, 1'b1);
    expect_lit("after_rst", 8'h5A, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 99) < 70, 1'($urandom), $urandom_range(0, 99) < 4,
            1'($urandom), $urandom_range(0, 199) == 0);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
